mant_divider: RTL and testbench



---
 rtl/mant_divider_pkg.sv | 16 +
 rtl/mant_div_sub.sv | 59 +++++
 rtl/mant_divider.sv | 126 ++++++++++++
 tb/tb_mant_divider.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mant_divider_pkg.sv
// Shared constants and types for the radix-2 restoring mantissa divider.
package mant_divider_pkg;

    // Default fraction width and the widths derived from it.
    localparam int W_DEF  = 23;
    localparam int M_DEF  = W_DEF + 1;      // mantissa width with hidden bit
    localparam int N_DEF  = W_DEF + 3;      // quotient: 1 int + W frac + 2 guard/round
    localparam int CW_DEF = $clog2(N_DEF);  // iteration counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mant_div_sub.sv
// Combinational trial subtractor for the divider: o_diff = i_a - i_b computed
// as i_a + ~i_b + 1 with a parallel-prefix carry-lookahead network.
// o_borrow is set when i_b > i_a (no carry out of the top bit).
module mant_div_sub
    import mant_divider_pkg::*;
#(
    parameter int WD = M_DEF + 1
) (
    input  logic [WD-1:0] i_a,
    input  logic [WD-1:0] i_b,
    output logic [WD-1:0] o_diff,
    output logic          o_borrow
);
    localparam int LV = $clog2(WD);

    logic [WD-1:0] w_nb;
    logic [WD-1:0] w_p;
    logic [WD-1:0] w_g;
    logic [WD-1:0] w_carry;

    // Bitwise propagate/generate terms of i_a + ~i_b.
    always_comb begin
        w_nb = ~i_b;
        w_p  = i_a ^ w_nb;
        w_g  = i_a & w_nb;
    end

    // Kogge-Stone prefix: w_carry[i] is the carry out of bit i, with the +1
    // carry-in folded into the bit-0 generate term.
    always_comb begin : p_prefix
        logic [WD-1:0] g_cur;
        logic [WD-1:0] p_cur;
        logic [WD-1:0] g_nxt;
        logic [WD-1:0] p_nxt;
        g_cur    = w_g;
        g_cur[0] = w_g[0] | w_p[0];
        p_cur    = w_p;
        g_nxt    = g_cur;
        p_nxt    = p_cur;
        for (int l = 0; l < LV; l++) begin
            g_nxt = g_cur;
            p_nxt = p_cur;
            for (int i = (1 << l); i < WD; i++) begin
                g_nxt[i] = g_cur[i] | (p_cur[i] & g_cur[i - (1 << l)]);
                p_nxt[i] = p_cur[i] & p_cur[i - (1 << l)];
            end
            g_cur = g_nxt;
            p_cur = p_nxt;
        end
        w_carry = g_cur;
    end

    // Sum bits from the carries into each position; borrow is inverted carry out.
    always_comb begin
        o_diff   = w_p ^ {w_carry[WD-2:0], 1'b1};
        o_borrow = ~w_carry[WD-1];
    end

endmodule

// File: rtl/mant_divider.sv
// Sequential radix-2 restoring divider for normalized mantissas 1.f in [1,2).
// One quotient bit per cycle; the quotient carries 1 integer bit, W fraction
// bits and 2 guard/round bits, plus a sticky bit for the remainder.
// Optional build macro: MANT_DIVIDER_EARLY_TERM_EN -- finish as soon as the
// partial remainder becomes zero (exact divides complete early).
module mant_divider
    import mant_divider_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W:0]   a_mant,
    input  logic [W:0]   b_mant,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W+2:0] q,
    output logic         sticky
);
    localparam int            M    = W + 1;
    localparam int            N    = W + 3;
    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [M:0]      r_rem;
    logic [M-1:0]    r_div;
    logic [N-1:0]    r_q;
    logic            r_sticky;
    logic            r_in_ready;
    logic            r_out_valid;

    logic [M:0]      w_diff;
    logic            w_borrow;
    logic            w_qbit;
    logic [M:0]      w_rem_sel;
    logic [M:0]      w_rem_next;
    logic [N-1:0]    w_q_shift;
    logic            w_last;
    logic            w_finish;
    logic [N-1:0]    w_q_done;

    mant_div_sub #(
        .WD (M + 1)
    ) u_sub (
        .i_a      (r_rem),
        .i_b      ({1'b0, r_div}),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    // One restoring step: keep the difference when it did not borrow, then shift.
    // NOTE: every signal here is assigned on every path, so no latch can be inferred.
    always_comb begin
        w_qbit     = ~w_borrow;
        w_rem_sel  = w_borrow ? r_rem : w_diff;
        w_rem_next = w_rem_sel << 1;
        w_q_shift  = {r_q[N-2:0], w_qbit};
        w_last     = (r_count == LAST);
`ifdef MANT_DIVIDER_EARLY_TERM_EN
        // A zero remainder means every remaining quotient bit is zero.
        w_finish   = w_last || (w_rem_next == '0);
        w_q_done   = w_q_shift << (LAST - r_count);
`else
        w_finish   = w_last;
        w_q_done   = w_q_shift;
`endif
    end

    // Handshake FSM, iteration counter and remainder/quotient shift registers.
    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_rem       <= '0;
            r_div       <= '0;
            r_q         <= '0;
            r_sticky    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_div      <= b_mant;
                        r_rem      <= {1'b0, a_mant};
                        r_q        <= '0;
                        r_sticky   <= 1'b0;
                        r_count    <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    r_rem   <= w_rem_next;
                    r_count <= r_count + CW'(1);
                    r_q     <= w_q_shift;
                    if (w_finish) begin
                        r_q         <= w_q_done;
                        r_sticky    <= |w_rem_next;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign q         = r_q;
    assign sticky    = r_sticky;

endmodule

// File: tb/tb_mant_divider.sv
// Directed bench for mant_divider with hand-computed quotients, latency,
// backpressure and mid-operation reset. Honors MANT_DIVIDER_EARLY_TERM_EN.
module tb_mant_divider;

    localparam int M = 24;
    localparam int N = 26;
`ifdef MANT_DIVIDER_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] a_mant;
    logic [M-1:0] b_mant;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] q;
    logic         sticky;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mant_divider dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_mant    (a_mant),
        .b_mant    (b_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .sticky    (sticky)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present operands at a negedge; returns at the negedge after acceptance,
    // with the operand inputs scrambled to show they were latched.
    task automatic start(input logic [M-1:0] a, input logic [M-1:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("start_ready", in_ready, 1);
        a_mant   = a;
        b_mant   = b;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a_mant   = ~a;
        b_mant   = ~b;
    endtask

    // Count rising edges after acceptance until out_valid is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic finish_hs(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_hs_valid"}, out_valid, 0);
        check({tag, "_hs_ready"}, in_ready, 1);
    endtask

    task automatic run_vec(input string tag, input logic [M-1:0] a, input logic [M-1:0] b,
                           input logic [N-1:0] exp_q, input logic exp_s, input int lat_early);
        int lat;
        start(a, b);
        wait_done(lat);
        check({tag, "_lat"}, lat, EARLY ? lat_early : N);
        check({tag, "_q"}, q, exp_q);
        check({tag, "_sticky"}, sticky, exp_s);
        finish_hs(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_mant    = '0;
        b_mant    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_q", q, 0);
        check("rst_sticky", sticky, 0);

        // tag, a, b, expected q, expected sticky, early-term latency
        run_vec("one",          24'h800000, 24'h800000, 26'h2000000, 1'b0, 1);
        run_vec("two_thirds",   24'h800000, 24'hC00000, 26'h1555555, 1'b1, 26);
        run_vec("three_halves", 24'hC00000, 24'h800000, 26'h3000000, 1'b0, 2);
        run_vec("max_q",        24'hFFFFFF, 24'h800000, 26'h3FFFFFC, 1'b0, 24);
        run_vec("min_q",        24'h800000, 24'hFFFFFF, 26'h1000001, 1'b1, 26);
        run_vec("equal_hi",     24'hFFFFFF, 24'hFFFFFF, 26'h2000000, 1'b0, 1);

        // Illegal divisor (hidden bit clear): result undefined, must still finish.
        start(24'h800000, 24'h400000);
        wait_done(lat);
        check("illegal_lat", lat, N);
        finish_hs("illegal");

        // Backpressure, with in_valid held high carrying the next operands.
        a_mant   = 24'h800000;
        b_mant   = 24'hC00000;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_mant = 24'hFFFFFF;
        b_mant = 24'h800000;
        seen   = 1'b0;
        lat    = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) seen = 1'b1;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("bp_busy_ready", seen, 0);
        check("bp_lat", lat, N);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_hold_q", q, 26'h1555555);
            check("bp_hold_sticky", sticky, 1);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_ready", in_ready, 0);
        end
        finish_hs("bp");
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_next_accepted", in_ready, 0);
        wait_done(lat);
        check("bp_next_q", q, 26'h3FFFFFC);
        check("bp_next_sticky", sticky, 0);
        finish_hs("bp_next");

        // Reset at BUSY count=10 discards the in-flight divide.
        start(24'h800000, 24'hC00000);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_q", q, 0);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_valid", seen, 0);
        run_vec("post_rst", 24'hC00000, 24'h800000, 26'h3000000, 1'b0, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
